// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program counter with stall, branch/jump select, post-reset hold,
//            alignment fix-up and wrap to RESET_VECTOR past ADDR_LIMIT.
//            Optional return-address stack enabled by macro PC_RAS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] ADDR_LIMIT   = WIDTH'(260),
  parameter int               HOLD_CYCLES  = 1,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Branch,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Call,
  input  logic             Return,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus4,
  output logic             PCValid,
  output logic             Wrapped,
  output logic             AlignErr,
  output logic             RasEmpty
);

  typedef enum logic [0:0] {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] C_HOLD      = 4'(HOLD_CYCLES);
  localparam state_t     C_RST_STATE = (HOLD_CYCLES > 0) ? ST_HOLD : ST_RUN;
  localparam logic       C_RST_VALID = (HOLD_CYCLES == 0);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_hold_cnt, w_hold_cnt_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt;
  logic             r_pcvalid, w_pcvalid_nxt;
  logic             r_wrapped, w_wrapped_nxt;
  logic             r_alignerr, w_alignerr_nxt;

  logic [WIDTH-1:0] w_pcplus4;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_target_al;
  logic             w_run_go;
  logic             w_ras_pop;
  logic [WIDTH-1:0] w_ras_top;

  assign w_pcplus4 = r_pc + WIDTH'(4);
  assign w_run_go  = (r_state == ST_RUN) && !Stall;

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_wp, w_wp_inc, w_wp_dec;
  logic [CNT_W-1:0] r_ras_cnt, w_ras_cnt_nxt;
  logic             w_ras_push;
  logic             r_rasempty;

  // r_wp is the next free slot; the top of stack sits just below it.
  assign w_wp_inc   = (r_wp == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_wp + PTR_W'(1);
  assign w_wp_dec   = (r_wp == '0) ? PTR_W'(RAS_DEPTH - 1) : r_wp - PTR_W'(1);
  assign w_ras_top  = r_ras[w_wp_dec];
  assign w_ras_pop  = w_run_go && Return && (r_ras_cnt != '0);
  assign w_ras_push = w_run_go && Jump && Call;

  always_comb begin
    w_ras_cnt_nxt = r_ras_cnt;
    if (w_ras_push && !w_ras_pop && (r_ras_cnt != CNT_W'(RAS_DEPTH)))
      w_ras_cnt_nxt = r_ras_cnt + CNT_W'(1);
    else if (w_ras_pop && !w_ras_push)
      w_ras_cnt_nxt = r_ras_cnt - CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wp       <= '0;
      r_ras_cnt  <= '0;
      r_rasempty <= 1'b1;
    end else begin
      r_ras_cnt  <= w_ras_cnt_nxt;
      r_rasempty <= (w_ras_cnt_nxt == '0);
      if (w_ras_push && !w_ras_pop)
        r_wp <= w_wp_inc;
      else if (w_ras_pop && !w_ras_push)
        r_wp <= w_wp_dec;
    end
  end

  // Pop-then-push in one cycle replaces the popped entry in place.
  always_ff @(posedge Clk) begin
    if (!Reset && w_ras_push) begin
      if (w_ras_pop)
        r_ras[w_wp_dec] <= w_pcplus4;
      else
        r_ras[r_wp] <= w_pcplus4;
    end
  end

  assign RasEmpty = r_rasempty;
`else
  logic w_unused_ras;
  assign w_unused_ras = Call ^ Return;
  assign w_ras_pop    = 1'b0;
  assign w_ras_top    = '0;
  assign RasEmpty     = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= C_RST_STATE;
      r_hold_cnt <= C_HOLD;
      r_pc       <= RESET_VECTOR;
      r_pcvalid  <= C_RST_VALID;
      r_wrapped  <= 1'b0;
      r_alignerr <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_pc       <= w_pc_nxt;
      r_pcvalid  <= w_pcvalid_nxt;
      r_wrapped  <= w_wrapped_nxt;
      r_alignerr <= w_alignerr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_pc_nxt       = r_pc;
    w_pcvalid_nxt  = r_pcvalid;
    w_wrapped_nxt  = 1'b0;
    w_alignerr_nxt = r_alignerr;
    w_target       = w_pcplus4;
    w_target_al    = w_pcplus4;
    case (r_state)
      ST_HOLD: begin
        if (r_hold_cnt <= 4'd1) begin
          w_hold_cnt_nxt = 4'd0;
          w_state_nxt    = ST_RUN;
          w_pcvalid_nxt  = 1'b1;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt - 4'd1;
        end
      end
      ST_RUN: begin
        if (!Stall) begin
          if (w_ras_pop)
            w_target = w_ras_top;
          else if (Jump)
            w_target = JumpTarget;
          else if (Branch)
            w_target = BranchTarget;
          w_target_al = {w_target[WIDTH-1:2], 2'b00};
          if (w_target[1:0] != 2'b00)
            w_alignerr_nxt = 1'b1;
          if (w_target_al > ADDR_LIMIT) begin
            w_pc_nxt      = RESET_VECTOR;
            w_wrapped_nxt = 1'b1;
          end else begin
            w_pc_nxt = w_target_al;
          end
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
      end
    endcase
  end

  assign PC       = r_pc;
  assign PCPlus4  = w_pcplus4;
  assign PCValid  = r_pcvalid;
  assign Wrapped  = r_wrapped;
  assign AlignErr = r_alignerr;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// Testbench for pc_sequencer: directed stimulus with queued expectations,
// checked by an independent monitor one step after each rising edge.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Branch, Jump, Call, Return;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] PC, PCPlus4;
  logic        PCValid, Wrapped, AlignErr, RasEmpty;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        v, w, a, e;
  } exp_t;

  exp_t q[$];

  pc_sequencer #(
    .WIDTH(32), .RESET_VECTOR(32'd0), .ADDR_LIMIT(32'd260),
    .HOLD_CYCLES(1), .RAS_DEPTH(2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Branch(Branch),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .Call(Call), .Return(Return), .PC(PC), .PCPlus4(PCPlus4),
    .PCValid(PCValid), .Wrapped(Wrapped), .AlignErr(AlignErr),
    .RasEmpty(RasEmpty)
  );

  always #5 Clk = ~Clk;

  // Monitor: every edge that has an expectation queued gets checked.
  initial begin
    exp_t x;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        tests_run++;
        if (PC !== x.pc || PCPlus4 !== (x.pc + 32'd4) || PCValid !== x.v ||
            Wrapped !== x.w || AlignErr !== x.a || RasEmpty !== x.e) begin
          tests_failed++;
          $display("FAIL %s: got pc=%h p4=%h v=%b w=%b a=%b e=%b, want pc=%h p4=%h v=%b w=%b a=%b e=%b",
                   x.nm, PC, PCPlus4, PCValid, Wrapped, AlignErr, RasEmpty,
                   x.pc, x.pc + 32'd4, x.v, x.w, x.a, x.e);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic t(input string nm, input bit rs, input bit st,
                   input bit jp, input logic [31:0] jt,
                   input bit br, input logic [31:0] bt,
                   input bit cl, input bit rt,
                   input logic [31:0] pc, input bit v, input bit w,
                   input bit a, input bit e);
    exp_t x;
    Reset = rs; Stall = st; Jump = jp; JumpTarget = jt;
    Branch = br; BranchTarget = bt; Call = cl; Return = rt;
    x.nm = nm; x.pc = pc; x.v = v; x.w = w; x.a = a; x.e = e;
    q.push_back(x);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Jump = 1'b0; Branch = 1'b0;
    Call = 1'b0; Return = 1'b0; JumpTarget = '0; BranchTarget = '0;
    @(negedge Clk);
    //     name        rs st jp jt      br bt      cl rt  pc      v  w  a  e
    t("rst0",     1, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 1);
    t("rst1",     1, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 1);
    t("hold",     0, 1, 1, 32'h80, 1, 32'h80, 0, 0, 32'h0,  1, 0, 0, 1);
    t("seq4",     0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h4,  1, 0, 0, 1);
    t("seq8",     0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h8,  1, 0, 0, 1);
    t("seq12",    0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'hC,  1, 0, 0, 1);
    t("seq16",    0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h10, 1, 0, 0, 1);
    t("stallpri", 0, 1, 1, 32'h40, 1, 32'h80, 0, 0, 32'h10, 1, 0, 0, 1);
    t("jumppri",  0, 0, 1, 32'h40, 1, 32'h80, 0, 0, 32'h40, 1, 0, 0, 1);
    t("branch",   0, 0, 0, 32'h40, 1, 32'h80, 0, 0, 32'h80, 1, 0, 0, 1);
    t("misalign", 0, 0, 1, 32'h43, 0, 32'h0,  0, 0, 32'h40, 1, 0, 1, 1);
    t("atlimit",  0, 0, 1, 32'h104,0, 32'h0,  0, 0, 32'h104,1, 0, 1, 1);
    t("seqwrapA", 0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,  1, 1, 1, 1);
    t("wrapclr",  0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h4,  1, 0, 1, 1);
    t("j256",     0, 0, 1, 32'h100,0, 32'h0,  0, 0, 32'h100,1, 0, 1, 1);
    t("seq260",   0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h104,1, 0, 1, 1);
    t("seqwrapB", 0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,  1, 1, 1, 1);
    t("brwrap",   0, 0, 0, 32'h0,  1, 32'h200,0, 0, 32'h0,  1, 1, 1, 1);
    t("afterwr",  0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h4,  1, 0, 1, 1);
`ifndef PC_RAS_EN
    t("retign",   0, 0, 0, 32'h0,  0, 32'h0,  0, 1, 32'h8,  1, 0, 1, 1);
    t("callplain",0, 0, 1, 32'h20, 0, 32'h0,  1, 1, 32'h20, 1, 0, 1, 1);
    t("retign2",  0, 0, 0, 32'h0,  0, 32'h0,  0, 1, 32'h24, 1, 0, 1, 1);
`endif
    t("j40",      0, 0, 1, 32'h40, 0, 32'h0,  0, 0, 32'h40, 1, 0, 1, 1);
    t("stall1",   0, 1, 1, 32'h80, 0, 32'h0,  0, 0, 32'h40, 1, 0, 1, 1);
    t("stallrst", 1, 1, 1, 32'h80, 0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 1);
    t("rehold",   0, 1, 1, 32'h80, 0, 32'h0,  0, 0, 32'h0,  1, 0, 0, 1);
    t("stall3",   0, 1, 1, 32'h80, 0, 32'h0,  0, 0, 32'h0,  1, 0, 0, 1);
    t("resume",   0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h4,  1, 0, 0, 1);
`ifdef PC_RAS_EN
    t("r_rst",    1, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 1);
    t("r_rel",    0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,  1, 0, 0, 1);
    t("r_seq4",   0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h4,  1, 0, 0, 1);
    t("r_seq8",   0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h8,  1, 0, 0, 1);
    t("call20",   0, 0, 1, 32'h20, 0, 32'h0,  1, 0, 32'h20, 1, 0, 0, 0);
    t("call30",   0, 0, 1, 32'h30, 0, 32'h0,  1, 0, 32'h30, 1, 0, 0, 0);
    t("ret24",    0, 0, 0, 32'h0,  0, 32'h0,  0, 1, 32'h24, 1, 0, 0, 0);
    t("retC",     0, 0, 0, 32'h0,  0, 32'h0,  0, 1, 32'hC,  1, 0, 0, 1);
    t("retempty", 0, 0, 0, 32'h0,  0, 32'h0,  0, 1, 32'h10, 1, 0, 0, 1);
    t("call40",   0, 0, 1, 32'h40, 0, 32'h0,  1, 0, 32'h40, 1, 0, 0, 0);
    t("call50",   0, 0, 1, 32'h50, 0, 32'h0,  1, 0, 32'h50, 1, 0, 0, 0);
    t("callfull", 0, 0, 1, 32'h60, 0, 32'h0,  1, 0, 32'h60, 1, 0, 0, 0);
    t("ret54",    0, 0, 0, 32'h0,  0, 32'h0,  0, 1, 32'h54, 1, 0, 0, 0);
    t("ret44",    0, 0, 0, 32'h0,  0, 32'h0,  0, 1, 32'h44, 1, 0, 0, 1);
    t("retovw",   0, 0, 0, 32'h0,  0, 32'h0,  0, 1, 32'h48, 1, 0, 0, 1);
    t("call80",   0, 0, 1, 32'h80, 0, 32'h0,  1, 0, 32'h80, 1, 0, 0, 0);
    t("poppush",  0, 0, 1, 32'h90, 0, 32'h0,  1, 1, 32'h4C, 1, 0, 0, 0);
    t("ret84",    0, 0, 0, 32'h0,  0, 32'h0,  0, 1, 32'h84, 1, 0, 0, 1);
`endif
    Reset = 1'b0; Stall = 1'b1; Jump = 1'b0; Branch = 1'b0;
    Call = 1'b0; Return = 1'b0;
    repeat (3) @(negedge Clk);
    if (q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
